// File: rtl/spi_peripheral_sync.sv
// SPI mode-0 peripheral that oversamples CS_N/SCK/COPI on clk and drives a register-file port.
// Supports sized items, burst auto-increment, a read strobe with 1-clk rdata latency and an illegal-opcode flag.
module spi_peripheral_sync #(
  parameter int RF_AWIDTH   = 6,
  parameter int RF_WIDTH    = 32,
  parameter int ADDR_BYTES  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CS_N,
  input  logic                  SCK,
  input  logic                  COPI,
  output logic                  CIPO,
  output logic [RF_AWIDTH-1:0]  addr,
  output logic                  re,
  output logic                  we,
  output logic [RF_WIDTH-1:0]   wdata,
  output logic [RF_WIDTH/8-1:0] wmask,
  input  logic [RF_WIDTH-1:0]   rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int RF_MASK   = RF_WIDTH / 8;
  localparam int MAX_SZ    = $clog2(RF_MASK);
  localparam int BA_W      = RF_AWIDTH + MAX_SZ;
  localparam int ADDR_BITS = ADDR_BYTES * 8;
  localparam int AX_W      = (BA_W > ADDR_BITS) ? BA_W : ADDR_BITS;
  localparam int SH_W      = (RF_WIDTH > 16) ? RF_WIDTH : 16;
  localparam int LW        = (MAX_SZ > 0) ? MAX_SZ : 1;
  localparam int CNT_W     = 7;
  localparam int ST_W      = $clog2(SYNC_STAGES + 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, OPCODE, ADDR, DATA, DONE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, copi_sync;
  logic                   sck_prev;
  logic                   cs_s, sck_s, copi_s, sck_rise, sck_fall;
  logic [ST_W-1:0]        settle_cnt;
  logic                   settled;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SH_W-1:0]        rx, rx_nxt;
  logic [RF_WIDTH-1:0]    tx;
  logic [1:0]             sz_q;
  logic                   wr_q, burst_q;
  logic [BA_W-1:0]        byte_addr;
  logic [LW-1:0]          rd_lane;
  logic                   re_p1;
  logic [1:0]             op_sz;
  logic                   op_illegal, op_last, addr_last, item_last;
  logic [AX_W-1:0]        addr_ext;
  logic [BA_W-1:0]        addr_in;

  function automatic logic [BA_W-1:0] align_addr(input logic [BA_W-1:0] ba, input logic [1:0] sz);
    logic [BA_W-1:0] low;
    low = (BA_W'(1) << sz) - BA_W'(1);
    return ba & ~low;
  endfunction

  function automatic logic [BA_W-1:0] step_of(input logic [1:0] sz);
    return BA_W'(1) << sz;
  endfunction

  function automatic logic [RF_AWIDTH-1:0] word_of(input logic [BA_W-1:0] ba);
    return RF_AWIDTH'(ba >> MAX_SZ);
  endfunction

  function automatic logic [LW-1:0] lane_of(input logic [BA_W-1:0] ba);
    return LW'(ba & BA_W'(RF_MASK - 1));
  endfunction

  function automatic logic [RF_MASK-1:0] lane_mask(input logic [1:0] sz, input logic [LW-1:0] lane);
    logic [31:0] m;
    m = (32'd1 << (32'd1 << sz)) - 32'd1;
    return RF_MASK'(m << lane);
  endfunction

  function automatic logic [RF_WIDTH-1:0] replicate(input logic [SH_W-1:0] item, input logic [1:0] sz);
    logic [RF_WIDTH-1:0] it, w;
    int nb_bytes;
    nb_bytes = 1 << sz;
    it = RF_WIDTH'(item) & ((RF_WIDTH'(1) << (nb_bytes * 8)) - RF_WIDTH'(1));
    w  = '0;
    for (int k = 0; k < RF_MASK; k++)
      if ((k % nb_bytes) == 0) w = w | (it << (k * 8));
    return w;
  endfunction

  // Lane slice left-justified so the item MSB sits at the shifter top.
  function automatic logic [RF_WIDTH-1:0] tx_load(input logic [RF_WIDTH-1:0] d,
                                                  input logic [LW-1:0] lane,
                                                  input logic [1:0] sz);
    logic [RF_WIDTH-1:0] s;
    s = d >> (int'(lane) * 8);
    return s << (RF_WIDTH - (8 << sz));
  endfunction

  // Input synchronisers, cleared to the idle bus state
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      copi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
      sck_prev  <= sck_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign copi_s   = copi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  // After reset the chain still holds the idle value; wait until it reflects the real pins.
  assign settled  = (settle_cnt == ST_W'(SYNC_STAGES));

  assign rx_nxt     = {rx[SH_W-2:0], copi_s};
  assign op_sz      = rx_nxt[1:0];
  assign op_illegal = (32'(op_sz) > MAX_SZ);
  assign op_last    = (bit_cnt == CNT_W'(7));
  assign addr_last  = (bit_cnt == CNT_W'(ADDR_BITS - 1));
  assign item_last  = (bit_cnt == CNT_W'((8 << sz_q) - 1));
  assign addr_ext   = AX_W'(rx_nxt[ADDR_BITS-1:0]);
  assign addr_in    = align_addr(addr_ext[BA_W-1:0], sz_q);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (settled && cs_s) state_nxt = IDLE;
      IDLE:      if (!cs_s) state_nxt = OPCODE;
      OPCODE:    if (sck_rise && op_last) state_nxt = op_illegal ? DONE : ADDR;
      ADDR:      if (sck_rise && addr_last) state_nxt = DATA;
      DATA:      if (sck_rise && item_last && !burst_q) state_nxt = DONE;
      DONE:      state_nxt = DONE;
      default:   state_nxt = WAIT_IDLE;
    endcase
    if (state != WAIT_IDLE && cs_s) state_nxt = IDLE;
  end

  // Frame datapath: shifters, address tracking and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      bit_cnt    <= '0;
      sz_q       <= '0;
      wr_q       <= 1'b0;
      burst_q    <= 1'b0;
      byte_addr  <= '0;
      rd_lane    <= '0;
      re_p1      <= 1'b0;
      CIPO       <= 1'b0;
      re         <= 1'b0;
      we         <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      wmask      <= '0;
    end else begin
      re    <= 1'b0;
      we    <= 1'b0;
      err   <= 1'b0;
      re_p1 <= re;
      busy  <= (state_nxt == OPCODE) || (state_nxt == ADDR) ||
               (state_nxt == DATA)   || (state_nxt == DONE);
      if (state == WAIT_IDLE && !settled) settle_cnt <= settle_cnt + ST_W'(1);

      if (state != WAIT_IDLE && cs_s) begin
        bit_cnt <= '0;
        CIPO    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            CIPO    <= 1'b0;
          end
          OPCODE: if (sck_rise) begin
            rx <= rx_nxt;
            if (op_last) begin
              bit_cnt <= '0;
              sz_q    <= op_sz;
              wr_q    <= rx_nxt[2];
              burst_q <= rx_nxt[3];
              err     <= op_illegal;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ADDR: if (sck_rise) begin
            rx <= rx_nxt;
            if (addr_last) begin
              bit_cnt <= '0;
              if (wr_q) begin
                byte_addr <= addr_in;
              end else begin
                re        <= 1'b1;
                addr      <= word_of(addr_in);
                rd_lane   <= lane_of(addr_in);
                byte_addr <= addr_in + step_of(sz_q);
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          DATA: begin
            if (sck_rise) begin
              rx <= rx_nxt;
              if (item_last) begin
                bit_cnt <= '0;
                if (wr_q) begin
                  we        <= 1'b1;
                  addr      <= word_of(byte_addr);
                  wdata     <= replicate(rx_nxt, sz_q);
                  wmask     <= lane_mask(sz_q, lane_of(byte_addr));
                  byte_addr <= byte_addr + step_of(sz_q);
                end else if (burst_q) begin
                  re        <= 1'b1;
                  addr      <= word_of(byte_addr);
                  rd_lane   <= lane_of(byte_addr);
                  byte_addr <= byte_addr + step_of(sz_q);
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            if (sck_fall && !wr_q) begin
              CIPO <= tx[RF_WIDTH-1];
              tx   <= tx << 1;
            end
          end
          DONE:    CIPO <= 1'b0;
          default: CIPO <= 1'b0;
        endcase
      end

      // rdata is valid the cycle after re; take the lane slice then
      if (re_p1) tx <= tx_load(rdata, rd_lane, sz_q);
    end
  end

endmodule

// File: tb/tb_spi_peripheral_sync.sv
// Directed bench for spi_peripheral_sync: bit-banged SPI frames, strobe log and hand-computed expectations.
module tb_spi_peripheral_sync;

  localparam int AW = 4;  // 4-bit word address so a burst from byte 0x3E wraps to 0
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          CS_N, SCK, COPI;
  logic          CIPO;
  logic [AW-1:0] addr;
  logic          re, we;
  logic [DW-1:0] wdata;
  logic [3:0]    wmask;
  logic [DW-1:0] rdata;
  logic          busy, err;

  int n_total = 0;
  int n_bad   = 0;

  int re_cnt = 0, we_cnt = 0, err_cnt = 0, cipo_cnt = 0, busy_cnt = 0, both_cnt = 0;
  logic [AW-1:0] re_addr_log [8];
  logic [AW-1:0] we_addr_log [8];
  logic [DW-1:0] we_data_log [8];
  logic [3:0]    we_mask_log [8];
  logic [DW-1:0] rd_val = '0;

  spi_peripheral_sync #(
    .RF_AWIDTH(AW), .RF_WIDTH(DW), .ADDR_BYTES(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .CS_N(CS_N), .SCK(SCK), .COPI(COPI), .CIPO(CIPO),
    .addr(addr), .re(re), .we(we), .wdata(wdata), .wmask(wmask),
    .rdata(rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Register-file model: fixed one-clock read latency
  always @(posedge clk) if (re) rdata <= rd_val;

  always @(negedge clk) begin
    if (re) begin
      re_addr_log[re_cnt % 8] = addr;
      re_cnt++;
    end
    if (we) begin
      we_addr_log[we_cnt % 8] = addr;
      we_data_log[we_cnt % 8] = wdata;
      we_mask_log[we_cnt % 8] = wmask;
      we_cnt++;
    end
    if (err) err_cnt++;
    if (CIPO) cipo_cnt++;
    if (busy) busy_cnt++;
    if (re && we) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic frame_begin();
    @(negedge clk) CS_N = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    CS_N = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Mode 0: COPI set while SCK low, CIPO sampled just before the rising edge.
  task automatic spi_bits(input logic [63:0] val, input int n, output logic [63:0] got);
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk) COPI = val[i];
      repeat (4) @(negedge clk);
      got = {got[62:0], CIPO};
      SCK = 1'b1;
      repeat (5) @(negedge clk);
      SCK = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] got;
    int r0, w0, e0, c0, b0;

    rst = 1'b1; CS_N = 1'b1; SCK = 1'b0; COPI = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cipo", {63'd0, CIPO}, 64'd0);
    chk("rst_strobes", {60'd0, re, we, err, busy}, 64'd0);
    chk("rst_addr", {60'd0, addr}, 64'd0);
    chk("rst_wdata", {32'd0, wdata}, 64'd0);
    chk("rst_wmask", {60'd0, wmask}, 64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // 1: word write
    w0 = we_cnt; r0 = re_cnt; c0 = cipo_cnt;
    frame_begin();
    spi_bits(64'h06, 8, got);
    chk("t1_busy_mid", {63'd0, busy}, 64'd1);
    spi_bits(64'h08, 8, got);
    spi_bits(64'hDEADBEEF, 32, got);
    frame_end();
    chk("t1_we_cnt", 64'(we_cnt - w0), 64'd1);
    chk("t1_addr", {60'd0, we_addr_log[w0 % 8]}, 64'd2);
    chk("t1_wdata", {32'd0, we_data_log[w0 % 8]}, 64'hDEADBEEF);
    chk("t1_wmask", {60'd0, we_mask_log[w0 % 8]}, 64'hF);
    chk("t1_no_re", 64'(re_cnt - r0), 64'd0);
    chk("t1_cipo_low", 64'(cipo_cnt - c0), 64'd0);
    chk("t1_busy_after", {63'd0, busy}, 64'd0);

    // 2: byte read from byte address 5, lane 1 of word 1
    rd_val = 32'h11223344;
    r0 = re_cnt; w0 = we_cnt;
    frame_begin();
    spi_bits(64'h00, 8, got);
    spi_bits(64'h05, 8, got);
    spi_bits(64'h00, 8, got);
    frame_end();
    chk("t2_re_cnt", 64'(re_cnt - r0), 64'd1);
    chk("t2_re_addr", {60'd0, re_addr_log[r0 % 8]}, 64'd1);
    chk("t2_cipo_byte", got & 64'hFF, 64'h33);
    chk("t2_no_we", 64'(we_cnt - w0), 64'd0);

    // 3: halfword burst write wrapping past the top of the address space
    w0 = we_cnt;
    frame_begin();
    spi_bits(64'h0D, 8, got);
    spi_bits(64'h3E, 8, got);
    spi_bits(64'hAAAA, 16, got);
    spi_bits(64'h5555, 16, got);
    frame_end();
    chk("t3_we_cnt", 64'(we_cnt - w0), 64'd2);
    chk("t3_addr0", {60'd0, we_addr_log[w0 % 8]}, 64'd15);
    chk("t3_mask0", {60'd0, we_mask_log[w0 % 8]}, 64'hC);
    chk("t3_data0", {32'd0, we_data_log[w0 % 8]}, 64'hAAAAAAAA);
    chk("t3_addr1", {60'd0, we_addr_log[(w0 + 1) % 8]}, 64'd0);
    chk("t3_mask1", {60'd0, we_mask_log[(w0 + 1) % 8]}, 64'h3);
    chk("t3_data1", {32'd0, we_data_log[(w0 + 1) % 8]}, 64'h55555555);

    // 4: illegal size
    e0 = err_cnt; r0 = re_cnt; w0 = we_cnt; c0 = cipo_cnt;
    frame_begin();
    spi_bits(64'h03, 8, got);
    spi_bits(64'hFFFF, 16, got);
    frame_end();
    chk("t4_err_cnt", 64'(err_cnt - e0), 64'd1);
    chk("t4_no_strobe", 64'((re_cnt - r0) + (we_cnt - w0)), 64'd0);
    chk("t4_cipo_low", 64'(cipo_cnt - c0), 64'd0);

    // 5: truncated word write, then a byte write to lane 1
    w0 = we_cnt;
    frame_begin();
    spi_bits(64'h06, 8, got);
    spi_bits(64'h00, 8, got);
    spi_bits(64'hFFFFF, 20, got);
    frame_end();
    chk("t5_partial_no_we", 64'(we_cnt - w0), 64'd0);
    frame_begin();
    spi_bits(64'h04, 8, got);
    spi_bits(64'h01, 8, got);
    spi_bits(64'h7E, 8, got);
    frame_end();
    chk("t5_we_cnt", 64'(we_cnt - w0), 64'd1);
    chk("t5_addr", {60'd0, we_addr_log[w0 % 8]}, 64'd0);
    chk("t5_wmask", {60'd0, we_mask_log[w0 % 8]}, 64'h2);
    chk("t5_wdata", {32'd0, we_data_log[w0 % 8]}, 64'h7E7E7E7E);

    // 6: reset in the middle of a word read
    rd_val = 32'h89ABCDEF;
    r0 = re_cnt;
    frame_begin();
    spi_bits(64'h02, 8, got);
    spi_bits(64'h04, 8, got);
    spi_bits(64'h0, 10, got);
    chk("t6_pre_re", 64'(re_cnt - r0), 64'd1);
    chk("t6_pre_bits", got & 64'h3FF, 64'h226);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("t6_rst_cipo", {63'd0, CIPO}, 64'd0);
    chk("t6_rst_strobes", {60'd0, re, we, err, busy}, 64'd0);
    chk("t6_rst_addr", {60'd0, addr}, 64'd0);
    chk("t6_rst_wmask", {60'd0, wmask}, 64'd0);
    r0 = re_cnt; w0 = we_cnt; c0 = cipo_cnt; b0 = busy_cnt;
    spi_bits(64'h0, 22, got);
    frame_end();
    chk("t6_ignored_strobes", 64'((re_cnt - r0) + (we_cnt - w0)), 64'd0);
    chk("t6_ignored_cipo", 64'(cipo_cnt - c0), 64'd0);
    chk("t6_ignored_busy", 64'(busy_cnt - b0), 64'd0);
    rd_val = 32'hCAFE0123;
    r0 = re_cnt;
    frame_begin();
    spi_bits(64'h02, 8, got);
    spi_bits(64'h04, 8, got);
    spi_bits(64'h0, 32, got);
    frame_end();
    chk("t6_next_re_cnt", 64'(re_cnt - r0), 64'd1);
    chk("t6_next_re_addr", {60'd0, re_addr_log[r0 % 8]}, 64'd1);
    chk("t6_next_word", got & 64'hFFFFFFFF, 64'hCAFE0123);

    chk("re_we_exclusive", 64'(both_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
